// File: rtl/dac_pkg.sv
// Shared definitions for the PCM5102 I2S link controller.
// Holds the controller state encoding, the default prescaler ratio and the
// helper that derives the number of BCK slots in one stereo frame.
package dac_pkg;

  // 28 MHz / (2*4) = 3.5 MHz BCK
  localparam int DEFAULT_CLK_DIV = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // One slot per bit, left then right
  function automatic int frame_slots(input int sample_w);
    return 2 * sample_w;
  endfunction

endpackage

// File: rtl/i2s_dac_ctrl_if.sv
// Sample hand-off bus between an upstream audio source and i2s_dac_ctrl.
//   sample_valid : source has a stereo sample on left/right
//   sample_ready : controller holding register is empty
//   left/right   : two's complement channel words
// A transfer happens on a clock where sample_valid && sample_ready.
interface i2s_dac_ctrl_if #(
  parameter int SAMPLE_W = 16
);
  logic                sample_valid;
  logic                sample_ready;
  logic [SAMPLE_W-1:0] left;
  logic [SAMPLE_W-1:0] right;

  modport master (output sample_valid, output left, output right, input sample_ready);
  modport slave  (input sample_valid, input left, input right, output sample_ready);
endinterface

// File: rtl/i2s_bck_gen.sv
// BCK prescaler: divides clk by 2*CLK_DIV using a clock-enable counter.
//   clk, reset : system clock, synchronous active-high reset
//   run        : count while high, hold while low
//   clr        : force counter and bck to 0 (dominates run)
//   bck        : registered bit clock
//   rise/fall  : one-cycle strobes on the clk before bck goes 0->1 / 1->0
module i2s_bck_gen
  import dac_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic bck,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt_q, div_cnt_d;
  logic       bck_q, bck_d;
  logic       tick;

  // Next-state for the divider and bck toggle
  always_comb begin
    tick      = 1'b0;
    div_cnt_d = div_cnt_q;
    bck_d     = bck_q;
    if (clr) begin
      div_cnt_d = 8'd0;
      bck_d     = 1'b0;
    end else if (run) begin
      if (div_cnt_q == DIV_MAX) begin
        tick      = 1'b1;
        div_cnt_d = 8'd0;
        bck_d     = ~bck_q;
      end else begin
        div_cnt_d = div_cnt_q + 8'd1;
      end
    end else begin
      div_cnt_d = div_cnt_q;
      bck_d     = bck_q;
    end
  end

  // Divider and bck registers
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= 8'd0;
      bck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bck_q     <= bck_d;
    end
  end

  assign bck  = bck_q;
  assign rise = tick & ~bck_q;
  assign fall = tick & bck_q;

endmodule

// File: rtl/i2s_dac_ctrl.sv
// I2S serialiser and sample handshake for the PCM5102 stereo DAC.
//   clk, reset    : system clock, synchronous active-high reset
//   en            : run request, honoured only at frame boundaries
//   mute          : zero the transmitted frame, sampled at frame load
//   smp           : sample hand-off bus (slave side)
//   frame_start   : one-cycle pulse during each frame load cycle
//   underflow_cnt : saturating count of loads with an empty holding register
//   underflow_clr : clears underflow_cnt (wins over a same-cycle increment)
//   bck/lrck/din  : DAC pins, all registered
module i2s_dac_ctrl
  import dac_pkg::*;
#(
  parameter int CLK_DIV        = DEFAULT_CLK_DIV,
  parameter int SAMPLE_W       = 16,
  parameter int UNDERFLOW_ZERO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          mute,
  i2s_dac_ctrl_if.slave smp,
  output logic          frame_start,
  output logic [7:0]    underflow_cnt,
  input  logic          underflow_clr,
  output logic          bck,
  output logic          lrck,
  output logic          din
);

  localparam int              SLOTS     = frame_slots(SAMPLE_W);
  localparam int              CW        = $clog2(SLOTS);
  localparam logic [CW-1:0]   LAST_SLOT = CW'(SLOTS - 1);
  localparam logic [CW-1:0]   RIGHT_SLOT = CW'(SAMPLE_W);

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SLOTS-1:0] word_q, word_d;   // word on the wire (mute applied)
  logic [SLOTS-1:0] last_q, last_d;   // last un-muted source word
  logic [SLOTS-1:0] hold_q, hold_d;
  logic             ready_q, ready_d; // holding register empty
  logic             lrck_q, lrck_d;
  logic             din_q, din_d;
  logic             fs_q, fs_d;
  logic [7:0]       ucnt_q, ucnt_d;

  logic             fall;
  logic             bck_rise_unused;
  logic             xfer;
  logic             ucnt_inc;
  logic [SLOTS-1:0] src;
  logic [CW-1:0]    nxt_slot;

  // Prescaler runs from the LOAD cycle, which is the first clk of slot 0
  i2s_bck_gen #(.CLK_DIV(CLK_DIV)) u_bck_gen (
    .clk   (clk),
    .reset (reset),
    .run   (state_q != IDLE),
    .clr   (state_q == IDLE),
    .bck   (bck),
    .rise  (bck_rise_unused),
    .fall  (fall)
  );

  // Next-state: FSM, serialiser, holding register and underflow counter
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    word_d    = word_q;
    last_d    = last_q;
    hold_d    = hold_q;
    ready_d   = ready_q;
    lrck_d    = lrck_q;
    din_d     = din_q;
    ucnt_d    = ucnt_q;
    ucnt_inc  = 1'b0;
    src       = '0;
    nxt_slot  = bit_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    xfer      = smp.sample_valid & ready_q;

    // Handshake is live in every state
    if (xfer) begin
      hold_d  = {smp.left, smp.right};
      ready_d = 1'b0;
    end else begin
      hold_d  = hold_q;
    end

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        lrck_d    = 1'b0;
        din_d     = 1'b0;
        if (en) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        state_d = RUN;
        // Fullness is judged on ready_q, so a same-cycle transfer only
        // refills holding for the next frame.
        if (!ready_q) begin
          src     = hold_q;
          ready_d = 1'b1;
        end else begin
          src      = (UNDERFLOW_ZERO != 0) ? '0 : last_q;
          ucnt_inc = 1'b1;
        end
        last_d = src;
        word_d = mute ? '0 : src;
      end
      RUN: begin
        if (fall) begin
          if (bit_cnt_q == LAST_SLOT) begin
            bit_cnt_d = '0;
            lrck_d    = 1'b0;
            // Right LSB rides in slot 0 of the next frame, or is dropped on stop
            if (en) begin
              state_d = LOAD;
              din_d   = word_q[0];
            end else begin
              state_d = IDLE;
              din_d   = 1'b0;
            end
          end else begin
            bit_cnt_d = nxt_slot;
            lrck_d    = (nxt_slot >= RIGHT_SLOT);
            // Slot s+1 carries word bit SLOTS-1-s (one-BCK I2S delay)
            din_d     = word_q[LAST_SLOT - bit_cnt_q];
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    fs_d = (state_d == LOAD);

    if (underflow_clr) begin
      ucnt_d = 8'd0;
    end else if (ucnt_inc && (ucnt_q != 8'hFF)) begin
      ucnt_d = ucnt_q + 8'd1;
    end else begin
      ucnt_d = ucnt_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      word_q    <= '0;
      last_q    <= '0;
      hold_q    <= '0;
      ready_q   <= 1'b1;
      lrck_q    <= 1'b0;
      din_q     <= 1'b0;
      fs_q      <= 1'b0;
      ucnt_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      word_q    <= word_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      ready_q   <= ready_d;
      lrck_q    <= lrck_d;
      din_q     <= din_d;
      fs_q      <= fs_d;
      ucnt_q    <= ucnt_d;
    end
  end

  assign smp.sample_ready = ready_q;
  assign frame_start      = fs_q;
  assign underflow_cnt    = ucnt_q;
  assign lrck             = lrck_q;
  assign din              = din_q;

endmodule

// File: tb/tb_i2s_dac_ctrl.sv
`timescale 1ns/1ps
module tb_i2s_dac_ctrl;

  localparam int CD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic en    = 1'b0;
  logic mute  = 1'b0;
  logic uclr  = 1'b0;
  logic frame_start, bck, lrck, din;
  logic [7:0] ucnt;

  // Zero-on-underflow copy fed the same samples
  logic din2, bck2, lrck2, fs2_unused;
  logic [7:0] ucnt2_unused;

  // Small-frame copy used for the long underflow run
  logic en3 = 1'b0;
  logic clr3 = 1'b0;
  logic fs3, bck3_unused, lrck3_unused, din3_unused;
  logic [7:0] ucnt3;

  always #5 clk = ~clk;

  i2s_dac_ctrl_if #(.SAMPLE_W(16)) if1 ();
  i2s_dac_ctrl_if #(.SAMPLE_W(16)) if2 ();
  i2s_dac_ctrl_if #(.SAMPLE_W(4))  if3 ();

  assign if2.sample_valid = if1.sample_valid;
  assign if2.left         = if1.left;
  assign if2.right        = if1.right;

  i2s_dac_ctrl #(.CLK_DIV(CD), .SAMPLE_W(16), .UNDERFLOW_ZERO(0)) dut (
    .clk(clk), .reset(reset), .en(en), .mute(mute), .smp(if1),
    .frame_start(frame_start), .underflow_cnt(ucnt), .underflow_clr(uclr),
    .bck(bck), .lrck(lrck), .din(din));

  i2s_dac_ctrl #(.CLK_DIV(CD), .SAMPLE_W(16), .UNDERFLOW_ZERO(1)) dut_zero (
    .clk(clk), .reset(reset), .en(en), .mute(mute), .smp(if2),
    .frame_start(fs2_unused), .underflow_cnt(ucnt2_unused), .underflow_clr(uclr),
    .bck(bck2), .lrck(lrck2), .din(din2));

  i2s_dac_ctrl #(.CLK_DIV(2), .SAMPLE_W(4), .UNDERFLOW_ZERO(0)) dut_small (
    .clk(clk), .reset(reset), .en(en3), .mute(1'b0), .smp(if3),
    .frame_start(fs3), .underflow_cnt(ucnt3), .underflow_clr(clr3),
    .bck(bck3_unused), .lrck(lrck3_unused), .din(din3_unused));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  // Scoreboard: one entry per frame, din slots packed slot0 at bit 31
  typedef struct packed {
    logic [31:0] slots;
    logic [7:0]  ucnt;
    logic        contig;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input logic [31:0] s, input logic [7:0] u, input logic c);
    exp_t e;
    e.slots = s; e.ucnt = u; e.contig = c;
    exp_q.push_back(e);
  endtask

  int   cyc = 0, fs_cur = 0, fs_prev = 0, slot = 0, n_fs = 0, off = 0;
  logic in_frame = 1'b0, bck_d = 1'b0, tim_bad = 1'b0;
  logic [31:0] cap = 32'd0;

  // Monitor: capture din on each bck rise, compare when a frame is complete
  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (reset) begin
      in_frame = 1'b0;
      bck_d    = 1'b0;
    end else begin
      if (frame_start === 1'b1) begin
        fs_prev = fs_cur; fs_cur = cyc; n_fs++;
        in_frame = 1'b1; slot = 0; cap = 32'd0; tim_bad = 1'b0;
      end
      if (in_frame) begin
        off = cyc - fs_cur;
        if (bck !== (((off / CD) % 2) == 1) || lrck !== (off >= 128)) tim_bad = 1'b1;
        if (bck === 1'b1 && bck_d === 1'b0) begin
          cap[31 - slot] = din;
          slot++;
        end
        if (slot == 32) begin
          in_frame = 1'b0;
          chk("sb_frame_expected", (exp_q.size() != 0), 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("din_slots", cap, e.slots);
            chk("bck_lrck_timing", tim_bad, 1'b0);
            chk("underflow_cnt", ucnt, e.ucnt);
            if (e.contig) chk("frame_period", fs_cur - fs_prev, 256);
          end
        end
      end
      bck_d = bck;
    end
  end

  // Zero-mode copy: equal to the main DUT in frame 1, silent once underflowing
  int   win2 = 0;
  logic bad_eq = 1'b0, bad_zero = 1'b0;
  initial forever begin
    @(negedge clk);
    if (win2 == 1 && (din2 !== din || bck2 !== bck || lrck2 !== lrck)) bad_eq = 1'b1;
    if (win2 == 2 && din2 !== 1'b0) bad_zero = 1'b1;
  end

  task automatic wait_fs(input int max);
    logic got = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin got = 1'b1; break; end
    end
    chk("wait_frame_start", got, 1'b1);
  endtask

  task automatic wait_sb_empty(input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("sb_drained", (exp_q.size() == 0), 1'b1);
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    logic got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (if1.sample_ready === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("send_ready", got, 1'b1);
    if1.sample_valid = 1'b1; if1.left = l; if1.right = r;
    @(negedge clk);
    if1.sample_valid = 1'b0;
  endtask

  // Long underflow run on the small instance: saturation and clear-vs-increment
  logic done3 = 1'b0;
  initial begin
    int k = 0, c3 = 0, t1 = 0;
    if3.sample_valid = 1'b0; if3.left = 4'd0; if3.right = 4'd0;
    @(negedge clk);
    while (reset) @(negedge clk);
    en3 = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      c3++;
      if (fs3 === 1'b1) begin
        k++;
        if (k == 1) t1 = c3;
        if (k == 2) begin
          chk("small_frame_period", c3 - t1, 32);
          chk("small_first_underflow", ucnt3, 8'd1);
        end
        if (k == 256) chk("ucnt_reaches_255", ucnt3, 8'd255);
        if (k == 300) chk("ucnt_saturated", ucnt3, 8'd255);
        if (k == 301) begin
          clr3 = 1'b1;
          @(negedge clk);
          clr3 = 1'b0;
          chk("ucnt_clr_wins_over_inc", ucnt3, 8'd0);
          break;
        end
      end
    end
    chk("small_frames_seen", k, 301);
    done3 = 1'b1;
  end

  // Main directed sequence
  initial begin
    logic hold_bad, idle_bad;
    if1.sample_valid = 1'b0; if1.left = 16'd0; if1.right = 16'd0;
    repeat (4) @(negedge clk);
    chk("rst_bck", bck, 1'b0);
    chk("rst_lrck", lrck, 1'b0);
    chk("rst_din", din, 1'b0);
    chk("rst_ready", if1.sample_ready, 1'b1);
    chk("rst_frame_start", frame_start, 1'b0);
    chk("rst_ucnt", ucnt, 8'd0);
    reset = 1'b0;
    @(negedge clk);

    // First sample while idle, then hold valid against a full register
    send(16'hA5F0, 16'h0F0F);
    chk("ready_low_when_full", if1.sample_ready, 1'b0);
    if1.sample_valid = 1'b1; if1.left = 16'h1111; if1.right = 16'h2222;
    hold_bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (if1.sample_ready !== 1'b0) hold_bad = 1'b1;
    end
    if1.sample_valid = 1'b0;
    chk("ready_stays_low_while_full", hold_bad, 1'b0);

    push_exp(32'h52F80787, 8'd0, 1'b0);          // F1 A5F0/0F0F, slot0 = 0
    en = 1'b1;
    wait_fs(50);
    win2 = 1;
    push_exp(32'hD2F80787, 8'd1, 1'b1);          // F2 repeat, slot0 = 1

    wait_fs(400);
    win2 = 0;
    push_exp(32'hD2F80787, 8'd2, 1'b1);          // F3 repeat
    repeat (8) @(negedge clk);
    win2 = 2;

    wait_fs(400);
    @(negedge clk);
    send(16'h1234, 16'h5678);
    mute = 1'b1;
    push_exp(32'h80000000, 8'd2, 1'b1);          // F4 muted, slot0 = 1

    wait_fs(400);
    @(negedge clk);
    mute = 1'b0;
    chk("ready_after_muted_load", if1.sample_ready, 1'b1);
    push_exp(32'h091A2B3C, 8'd3, 1'b1);          // F5 repeats un-muted 1234/5678

    wait_fs(400);
    win2 = 0;
    chk("zero_mode_matches_frame1", bad_eq, 1'b0);
    chk("zero_mode_din_silent", bad_zero, 1'b0);
    push_exp(32'h091A2B3C, 8'd4, 1'b1);          // F6 underflow despite load-cycle transfer

    wait_fs(400);
    if1.sample_valid = 1'b1; if1.left = 16'hCAFE; if1.right = 16'hBEEF;
    @(negedge clk);
    if1.sample_valid = 1'b0;
    chk("ready_low_after_load_xfer", if1.sample_ready, 1'b0);
    push_exp(32'h657F5F77, 8'd4, 1'b1);          // F7 CAFE/BEEF

    wait_fs(400);
    repeat (44) @(negedge clk);
    en = 1'b0;
    wait_sb_empty(400);
    repeat (10) @(negedge clk);
    idle_bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (bck !== 1'b0 || lrck !== 1'b0 || din !== 1'b0 || frame_start !== 1'b0) idle_bad = 1'b1;
    end
    chk("idle_pins_low", idle_bad, 1'b0);
    chk("frames_before_idle", n_fs, 7);

    push_exp(32'h657F5F77, 8'd5, 1'b0);          // F8 after idle, slot0 = 0
    en = 1'b1;
    @(negedge clk);
    chk("load_next_cycle_after_en", frame_start, 1'b1);
    en = 1'b0;
    wait_sb_empty(400);
    chk("total_frames", n_fs, 8);

    for (int i = 0; i < 20000; i++) begin
      if (done3) break;
      @(negedge clk);
    end
    chk("small_run_done", done3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
